// File: rtl/spi_bus_arb_pkg.sv
// Shared types and defaults for the SPI bus arbiter: requester ids, FSM states,
// slave-select ids and the latched request payload.
package spi_bus_arb_pkg;

  localparam int unsigned GAP_CYC_DEF     = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 4096;
  localparam int unsigned CNT_W_DEF       = 13;
  localparam int unsigned CMD_W           = 16;
  localparam int unsigned NREQ            = 3;

  typedef enum logic [1:0] {
    REQ_GAIN = 2'd0,
    REQ_TRIG = 2'd1,
    REQ_EEP  = 2'd2
  } req_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_CH1  = 3'd0,
    SEL_CH2  = 3'd1,
    SEL_CH3  = 3'd2,
    SEL_TRIG = 3'd3,
    SEL_EEP  = 3'd4
  } sel_e;

  typedef struct packed {
    logic [1:0]       ch;
    logic [CMD_W-1:0] cmd;
  } slot_t;

  // Round-robin successor: gain -> trig -> eep -> gain.
  function automatic req_e next_req(input req_e r);
    req_e n;
    case (r)
      REQ_GAIN: n = REQ_TRIG;
      REQ_TRIG: n = REQ_EEP;
      default:  n = REQ_GAIN;
    endcase
    return n;
  endfunction

  // Slave select addressed by a granted requester (gain uses its pot channel).
  function automatic sel_e slot_sel(input req_e r, input logic [1:0] ch);
    sel_e s;
    case (r)
      REQ_TRIG: s = SEL_TRIG;
      REQ_EEP:  s = SEL_EEP;
      default: begin
        case (ch)
          2'b01:   s = SEL_CH2;
          2'b10:   s = SEL_CH3;
          default: s = SEL_CH1;
        endcase
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/spi_bus_arb_rr.sv
// Three-way round-robin grant: first pending requester at or after ptr.
module rr_arb3
  import spi_bus_arb_pkg::*;
(
  input  logic [NREQ-1:0] pend,
  input  req_e            ptr,
  output logic            vld,
  output req_e            gnt
);

  req_e c1;
  req_e c2;

  always_comb begin
    c1  = next_req(ptr);
    c2  = next_req(c1);
    vld = 1'b1;
    gnt = ptr;
    if (pend[ptr]) begin
      gnt = ptr;
    end else if (pend[c1]) begin
      gnt = c1;
    end else if (pend[c2]) begin
      gnt = c2;
    end else begin
      vld = 1'b0;
    end
  end

endmodule

// File: rtl/spi_bus_arb.sv
// Shares one SPI master between gain-pot, trigger-pot and EEPROM requesters,
// with round-robin grant, select routing, inter-transaction gap and timeout.
module spi_bus_arb
  import spi_bus_arb_pkg::*;
#(
  parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gain_req,
  input  logic [1:0]       gain_ch,
  input  logic [CMD_W-1:0] gain_cmd,
  output logic             gain_done,
  input  logic             trig_req,
  input  logic [CMD_W-1:0] trig_cmd,
  output logic             trig_done,
  input  logic             eep_req,
  input  logic [CMD_W-1:0] eep_cmd,
  output logic             eep_done,
  output logic [CMD_W-1:0] rsp_data,
  output logic             err,
  output logic             busy,
  output logic             spi_wrt,
  output logic [CMD_W-1:0] spi_cmd,
  input  logic             spi_done,
  input  logic [CMD_W-1:0] spi_rd,
  input  logic             spi_ss_n,
  output logic             ch1_ss_n,
  output logic             ch2_ss_n,
  output logic             ch3_ss_n,
  output logic             trig_ss_n,
  output logic             EEP_ss_n
);

  state_e           state;
  req_e             ptr;
  req_e             gnt_r;
  sel_e             sel;
  logic [NREQ-1:0]  pend;
  logic [NREQ-1:0]  done_q;
  slot_t            slot [NREQ];
  slot_t            in_slot [NREQ];
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  req_v;
  logic [NREQ-1:0]  cap;
  logic             arb_vld;
  req_e             arb_gnt;
  logic             ss_act;

  // Capture: illegal gain channel is dropped; a req coinciding with its own done is ignored.
  assign req_v = {eep_req, trig_req, gain_req && (gain_ch != 2'b11)};
  assign cap   = req_v & ~pend & ~done_q;

  assign in_slot[REQ_GAIN] = '{ch: gain_ch, cmd: gain_cmd};
  assign in_slot[REQ_TRIG] = '{ch: 2'b00,   cmd: trig_cmd};
  assign in_slot[REQ_EEP]  = '{ch: 2'b00,   cmd: eep_cmd};

  rr_arb3 u_arb (
    .pend (pend),
    .ptr  (ptr),
    .vld  (arb_vld),
    .gnt  (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= REQ_GAIN;
      gnt_r    <= REQ_GAIN;
      sel      <= SEL_CH1;
      pend     <= '0;
      done_q   <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      spi_wrt  <= 1'b0;
      spi_cmd  <= '0;
      rsp_data <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        slot[i] <= '0;
      end
    end else begin
      done_q  <= '0;
      err     <= 1'b0;
      spi_wrt <= 1'b0;

      for (int unsigned i = 0; i < NREQ; i++) begin
        if (cap[i]) begin
          pend[i] <= 1'b1;
          slot[i] <= in_slot[i];
        end
      end

      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            gnt_r   <= arb_gnt;
            sel     <= slot_sel(arb_gnt, slot[arb_gnt].ch);
            spi_cmd <= slot[arb_gnt].cmd;
            spi_wrt <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // spi_done has priority over a coincident timeout.
          if (spi_done || (cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
            rsp_data      <= spi_done ? spi_rd : '0;
            err           <= !spi_done;
            done_q[gnt_r] <= 1'b1;
            pend[gnt_r]   <= 1'b0;
            ptr           <= next_req(gnt_r);
            cnt           <= '0;
            state         <= ST_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYC - 1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gain_done = done_q[REQ_GAIN];
  assign trig_done = done_q[REQ_TRIG];
  assign eep_done  = done_q[REQ_EEP];

  // Master SS_n reaches only the selected slave, and only while a transfer is in flight.
  assign ss_act    = (state == ST_WAIT_DONE);
  assign ch1_ss_n  = !(ss_act && (sel == SEL_CH1))  || spi_ss_n;
  assign ch2_ss_n  = !(ss_act && (sel == SEL_CH2))  || spi_ss_n;
  assign ch3_ss_n  = !(ss_act && (sel == SEL_CH3))  || spi_ss_n;
  assign trig_ss_n = !(ss_act && (sel == SEL_TRIG)) || spi_ss_n;
  assign EEP_ss_n  = !(ss_act && (sel == SEL_EEP))  || spi_ss_n;

endmodule

// File: doc/spi_bus_arb.md
Name: spi_bus_arb

Overview:
Shares the single SPI master in the digital core between three requesters: the gain-pot writer (ch1/ch2/ch3 pots), the trigger-level pot writer and the calibration EEPROM read/write path. It latches one pending request per requester and grants them round-robin. It sequences each transaction on the SPI master, routes the master's SS_n to the selected slave's select line, and enforces an idle gap between transactions. It aborts with an error if the master never completes.

Parameters:
GAP_CYC, 8, minimum clk cycles with all slave selects high between two transactions (1..255)
TIMEOUT_CYC, 4096, clk cycles in WAIT_DONE before abort
CNT_W, 13, width of the shared gap/timeout counter (must hold TIMEOUT_CYC)

Ports:
clk  in  1  system clock
rst_n  in  1  reset: synchronous, active-low
gain_req  in  1  one-cycle request pulse from the gain writer
gain_ch  in  2  target pot: 00=ch1, 01=ch2, 10=ch3; 11 is illegal and the request is dropped
gain_cmd  in  16  SPI word for the gain pot
gain_done  out  1  one-cycle completion pulse
trig_req  in  1  trigger-level request pulse
trig_cmd  in  16  SPI word for the trigger pot
trig_done  out  1  completion pulse
eep_req  in  1  EEPROM request pulse
eep_cmd  in  16  SPI word for the EEPROM
eep_done  out  1  completion pulse
rsp_data  out  16  SPI read word; valid in the cycle any *_done is high
err  out  1  one-cycle pulse on timeout abort, coincident with that requester's *_done
busy  out  1  high in any state other than IDLE
spi_wrt  out  1  one-cycle start strobe to the SPI master
spi_cmd  out  16  word to the SPI master
spi_done  in  1  SPI master transaction-complete pulse
spi_rd  in  16  SPI master read data
spi_ss_n  in  1  SS_n generated by the SPI master
ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n  out  1 each  slave selects

Behaviour:
- Reset (synchronous, rst_n low at posedge clk):
  - state=IDLE, all pending slots cleared, RR pointer=gain.
  - All *_done, err, spi_wrt, busy = 0; rsp_data=0; spi_cmd=0.
  - All slave selects = 1.
  - Reset mid-transaction abandons it with no done pulse.
- Request capture:
  - On *_req with that slot empty, latch the payload (gain: gain_ch too) and set pending.
  - *_req while that slot is pending is ignored; the requester must wait for its *_done.
  - A req in the same cycle as its own *_done is ignored.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - If any slot is pending, grant in RR order starting at the pointer (gain -> trig -> eep -> gain).
  - Registers sel and spi_cmd, then goes to ISSUE.
  - A request captured in cycle N can be granted in cycle N+1 (visible pending); spi_wrt is high in cycle N+2.
- ISSUE: spi_wrt=1 for exactly one cycle; clear the counter; go to WAIT_DONE.
- WAIT_DONE:
  - The selected slave ss_n = spi_ss_n; all other selects = 1.
  - On spi_done: rsp_data<=spi_rd, pulse the granted *_done next cycle, clear its slot, set RR pointer to the requester after the granted one, go to GAP.
  - If counter reaches TIMEOUT_CYC-1 without spi_done: same as above but rsp_data<=16'h0000 and err pulses with *_done.
  - If spi_done and timeout occur in the same cycle, spi_done wins and there is no err.
- GAP:
  - All selects = 1.
  - Count GAP_CYC cycles, then go to IDLE. Requests are still captured during GAP.
- Select mapping: gain ch 00/01/10 -> ch1/ch2/ch3_ss_n; trig -> trig_ss_n; eep -> EEP_ss_n. sel is stable from ISSUE through WAIT_DONE.
- Outside WAIT_DONE all selects are forced to 1 regardless of spi_ss_n.
- Back-to-back: SPI-visible throughput is one transaction per (SPI time + GAP_CYC + 2) cycles.

Decomposition:
- Shared package holds:
  - requester enum {REQ_GAIN, REQ_TRIG, REQ_EEP}
  - state enum
  - slave-select enum {SEL_CH1, SEL_CH2, SEL_CH3, SEL_TRIG, SEL_EEP}
  - default GAP_CYC and TIMEOUT_CYC constants
- One natural sub-module: rr_arb3 (3-way round-robin grant from pending vector and pointer; purely combinational with registered pointer in parent).

Test Plan:
- Single transaction: gain_req with gain_ch=01, gain_cmd=16'h1234 -> spi_wrt 2 cycles later, spi_cmd=16'h1234, only ch2_ss_n follows spi_ss_n. Model spi_done with spi_rd=16'hA5A5 -> gain_done=1, rsp_data=16'hA5A5.
- Simultaneous requests: gain, trig and eep all requested in the same cycle -> grants in order gain, trig, eep. Each transaction separated by at least 8 cycles with all selects high.
- Fairness: gain re-requests immediately after each done while eep stays pending -> eep is granted before gain's second grant.
- Drop rule:
  - Second trig_req while trig is pending -> only one spi_wrt for trig, spi_cmd is the first payload.
  - gain_ch=11 -> no transaction, no done.
- Timeout: master never asserts spi_done -> exactly 4096 cycles after ISSUE, eep_done=1 and err=1 in the same cycle with rsp_data=0. Arbiter then goes to GAP and IDLE.
- Reset mid-WAIT_DONE: rst_n low for 1 cycle -> next cycle all selects=1, busy=0, no done. A subsequent spi_done is ignored.
